// File: rtl/clock_mode_control_if.sv
// Button inputs and counter-chain controls shared between a clock
// mode controller and whatever drives its buttons and watches its outputs.
interface clock_mode_control_if;
   logic i_Button_Mode;
   logic i_Button_Set;
   logic o_Reset_Sec;
   logic o_Enable_Increment;
   logic o_Enable_Count_Sec;
   logic o_Enable_Count_Min;
   logic o_Enable_Count_Hour;
   logic o_Set_Min;
   logic o_Set_Hour;

   modport slave (
      input  i_Button_Mode,
      input  i_Button_Set,
      output o_Reset_Sec,
      output o_Enable_Increment,
      output o_Enable_Count_Sec,
      output o_Enable_Count_Min,
      output o_Enable_Count_Hour,
      output o_Set_Min,
      output o_Set_Hour
   );

   modport master (
      output i_Button_Mode,
      output i_Button_Set,
      input  o_Reset_Sec,
      input  o_Enable_Increment,
      input  o_Enable_Count_Sec,
      input  o_Enable_Count_Min,
      input  o_Enable_Count_Hour,
      input  o_Set_Min,
      input  o_Set_Hour
   );
endinterface

// File: rtl/clock_mode_control.sv
// Digital-clock mode controller: run/set-hour/set-minute sequencing,
// seconds prescaler and Set-button auto-repeat.
//
// state       | meaning
// ST_RUN      | time runs, seconds prescaler active, Set ignored
// ST_SET_HOUR | hours field selected, seconds held clear
// ST_SET_MIN  | minutes field selected, no minute-to-hour carry
module clock_mode_control #(
   parameter int c_CLK_FREQ      = 50_000_000,
   parameter int c_REPEAT_DELAY  = c_CLK_FREQ / 2,
   parameter int c_REPEAT_PERIOD = c_CLK_FREQ / 8
) (
   input logic                 i_Clock,
   input logic                 i_Reset,
   clock_mode_control_if.slave bus
);
   localparam int PRESC_W = (c_CLK_FREQ > 1) ? $clog2(c_CLK_FREQ) : 1;
   localparam int RPT_MAX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ? c_REPEAT_DELAY : c_REPEAT_PERIOD;
   localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(c_CLK_FREQ - 1);
   localparam logic [RPT_W-1:0]   DELAY_LOAD  = RPT_W'(c_REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0]   PERIOD_LOAD = RPT_W'(c_REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               mode_prev, set_prev;
   logic               mode_edge, set_edge;
   logic               stay;
   logic [PRESC_W-1:0] presc, presc_nxt;
   logic [RPT_W-1:0]   rpt_cnt, rpt_cnt_nxt;
   logic               rpt_active, rpt_active_nxt;
   logic               tick_nxt, inc_nxt;
   logic               reset_sec_nxt, cnt_min_nxt, cnt_hour_nxt, set_min_nxt, set_hour_nxt;
   logic               reset_sec_q, inc_q, tick_q, cnt_min_q, cnt_hour_q, set_min_q, set_hour_q;

   assign mode_edge = bus.i_Button_Mode & ~mode_prev;
   assign set_edge  = bus.i_Button_Set & ~set_prev;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= ST_RUN;
         mode_prev   <= 1'b1;
         set_prev    <= 1'b1;
         presc       <= '0;
         rpt_cnt     <= '0;
         rpt_active  <= 1'b0;
         tick_q      <= 1'b0;
         inc_q       <= 1'b0;
         reset_sec_q <= 1'b1;
         cnt_min_q   <= 1'b0;
         cnt_hour_q  <= 1'b0;
         set_min_q   <= 1'b0;
         set_hour_q  <= 1'b0;
      end else begin
         state       <= state_nxt;
         mode_prev   <= bus.i_Button_Mode;
         set_prev    <= bus.i_Button_Set;
         presc       <= presc_nxt;
         rpt_cnt     <= rpt_cnt_nxt;
         rpt_active  <= rpt_active_nxt;
         tick_q      <= tick_nxt;
         inc_q       <= inc_nxt;
         reset_sec_q <= reset_sec_nxt;
         cnt_min_q   <= cnt_min_nxt;
         cnt_hour_q  <= cnt_hour_nxt;
         set_min_q   <= set_min_nxt;
         set_hour_q  <= set_hour_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      presc_nxt      = '0;
      tick_nxt       = 1'b0;
      inc_nxt        = 1'b0;
      rpt_cnt_nxt    = '0;
      rpt_active_nxt = 1'b0;
      reset_sec_nxt  = 1'b1;
      cnt_min_nxt    = 1'b0;
      cnt_hour_nxt   = 1'b0;
      set_min_nxt    = 1'b0;
      set_hour_nxt   = 1'b0;

      if (mode_edge) begin
         case (state)
            ST_RUN:      state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: state_nxt = ST_SET_MIN;
            default:     state_nxt = ST_RUN;
         endcase
      end
      stay = (state_nxt == state);

      // The prescaler only advances while RUN persists, so re-entering RUN starts from zero.
      if (state == ST_RUN && stay) begin
         if (presc == PRESC_LAST) begin
            tick_nxt = 1'b1;
         end else begin
            presc_nxt = presc + PRESC_W'(1);
         end
      end

      // A Mode edge wins over a simultaneous Set edge and cancels any repeat in progress.
      if (state != ST_RUN && stay && bus.i_Button_Set) begin
         if (set_edge) begin
            inc_nxt        = 1'b1;
            rpt_active_nxt = 1'b1;
            rpt_cnt_nxt    = DELAY_LOAD;
         end else if (rpt_active) begin
            rpt_active_nxt = 1'b1;
            if (rpt_cnt == '0) begin
               inc_nxt     = 1'b1;
               rpt_cnt_nxt = PERIOD_LOAD;
            end else begin
               rpt_cnt_nxt = rpt_cnt - RPT_W'(1);
            end
         end
      end

      case (state_nxt)
         ST_SET_HOUR: begin
            cnt_hour_nxt = 1'b1;
            set_hour_nxt = 1'b1;
         end
         ST_SET_MIN: begin
            cnt_min_nxt = 1'b1;
            set_min_nxt = 1'b1;
         end
         default: begin
            reset_sec_nxt = 1'b0;
            cnt_min_nxt   = 1'b1;
            cnt_hour_nxt  = 1'b1;
         end
      endcase
   end

   assign bus.o_Reset_Sec         = reset_sec_q;
   assign bus.o_Enable_Increment  = inc_q;
   assign bus.o_Enable_Count_Sec  = tick_q;
   assign bus.o_Enable_Count_Min  = cnt_min_q;
   assign bus.o_Enable_Count_Hour = cnt_hour_q;
   assign bus.o_Set_Min           = set_min_q;
   assign bus.o_Set_Hour          = set_hour_q;
endmodule

// File: tb/tb_clock_mode_control.sv
// Scoreboard bench for clock_mode_control: per-cycle expected outputs from a
// reference model, plus event-time checks for the headline scenarios.
module tb_clock_mode_control;
   localparam int F = 10;
   localparam int D = 6;
   localparam int P = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clock_mode_control_if bus ();

   clock_mode_control #(
      .c_CLK_FREQ(F), .c_REPEAT_DELAY(D), .c_REPEAT_PERIOD(P)
   ) dut (
      .i_Clock(clk),
      .i_Reset(rst),
      .bus    (bus)
   );

   typedef struct {
      int         cyc;
      logic [6:0] v;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   last_cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   tick_log[$];
   int   inc_log[$];

   // reference model: mode 0=run 1=set hour 2=set min
   int   m_mode = 0;
   bit   m_pm = 1'b1;
   bit   m_ps = 1'b1;
   int   m_run_age = 0;
   int   m_age = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_step(input bit r, input bit m, input bit s, output logic [6:0] v);
      bit me, se, tick, inc;
      int nxt;
      if (r) begin
         m_mode = 0; m_pm = 1'b1; m_ps = 1'b1; m_run_age = 0; m_age = -1;
         v = 7'b1000000;
      end else begin
         me = m && !m_pm;
         se = s && !m_ps;
         m_pm = m;
         m_ps = s;
         nxt  = me ? (m_mode + 1) % 3 : m_mode;
         tick = 1'b0;
         inc  = 1'b0;
         if (m_mode == 0 && nxt == 0) begin
            m_run_age++;
            tick = (m_run_age % F == 0);
         end else begin
            m_run_age = 0;
         end
         if (m_mode != 0 && nxt == m_mode && s) begin
            if (se) begin
               m_age = 0;
               inc = 1'b1;
            end else if (m_age >= 0) begin
               m_age++;
               inc = (m_age >= D) && ((m_age - D) % P == 0);
            end
         end else begin
            m_age = -1;
         end
         m_mode = nxt;
         case (m_mode)
            1:       v = {1'b1, inc, tick, 1'b0, 1'b1, 1'b0, 1'b1};
            2:       v = {1'b1, inc, tick, 1'b1, 1'b0, 1'b1, 1'b0};
            default: v = {1'b0, inc, tick, 1'b1, 1'b1, 1'b0, 1'b0};
         endcase
      end
   endtask

   task automatic drive(input bit r, input bit m, input bit s);
      logic [6:0] v;
      exp_t       e;
      @(posedge clk);
      #1;
      rst = r;
      bus.i_Button_Mode = m;
      bus.i_Button_Set  = s;
      model_step(r, m, s, v);
      e.cyc = cyc + 1;
      e.v   = v;
      sb_q.push_back(e);
      last_cyc = cyc;
   endtask

   task automatic check_log(input string name, input int got[$], input int want[$]);
      int bad;
      bad = -1;
      n_cmp++;
      if (got.size() != want.size()) begin
         n_fail++;
         $display("FAIL %s: got %0d events, want %0d", name, got.size(), want.size());
      end else begin
         for (int i = 0; i < want.size(); i++)
            if (bad < 0 && got[i] != want[i]) bad = i;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: event %0d at cycle %0d, want cycle %0d", name, bad, got[bad], want[bad]);
         end
      end
   endtask

   logic [6:0] mon_act;
   exp_t       mon_e;

   always @(negedge clk) begin
      mon_act = {bus.o_Reset_Sec, bus.o_Enable_Increment, bus.o_Enable_Count_Sec,
                 bus.o_Enable_Count_Min, bus.o_Enable_Count_Hour, bus.o_Set_Min, bus.o_Set_Hour};
      if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
         mon_e = sb_q.pop_front();
         n_cmp++;
         if (mon_e.cyc != cyc || mon_act !== mon_e.v) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d slot=%0d got=%b want=%b (rst_sec,inc,sec,min,hour,set_min,set_hour)",
                     cyc, mon_e.cyc, mon_act, mon_e.v);
         end
      end
      if (mon_act[5] === 1'b1) inc_log.push_back(cyc);
      if (mon_act[4] === 1'b1) tick_log.push_back(cyc);
   end

   initial begin
      int w[$];
      int n;
      bit rm, rs, rr;
      bus.i_Button_Mode = 1'b0;
      bus.i_Button_Set  = 1'b0;

      repeat (3) drive(1, 0, 0);

      // seconds ticks after reset release
      tick_log.delete();
      drive(0, 0, 0);
      n = last_cyc;
      repeat (36) drive(0, 0, 0);
      w = {}; w.push_back(n + 10); w.push_back(n + 20); w.push_back(n + 30);
      check_log("ticks_after_reset", tick_log, w);

      // RUN -> SET_HOUR -> SET_MIN
      drive(0, 1, 0);
      repeat (3) drive(0, 0, 0);
      drive(0, 1, 0);
      repeat (3) drive(0, 0, 0);

      // Set high for cycles n..n+15 in SET_MIN
      inc_log.delete();
      drive(0, 0, 1);
      n = last_cyc;
      repeat (15) drive(0, 0, 1);
      repeat (7) drive(0, 0, 0);
      w = {}; w.push_back(n + 1); w.push_back(n + 7); w.push_back(n + 10);
      w.push_back(n + 13); w.push_back(n + 16);
      check_log("auto_repeat", inc_log, w);

      // SET_MIN -> RUN, first tick F cycles after entering RUN
      tick_log.delete();
      drive(0, 1, 0);
      n = last_cyc;
      repeat (13) drive(0, 0, 0);
      w = {}; w.push_back(n + 11);
      check_log("first_tick_after_set", tick_log, w);

      // Set ignored in RUN; simultaneous Mode+Set gives SET_HOUR without increment
      inc_log.delete();
      repeat (3) begin
         drive(0, 0, 1);
         drive(0, 0, 0);
         drive(0, 0, 0);
      end
      repeat (10) drive(0, 1, 1);
      repeat (2) drive(0, 0, 0);
      w = {};
      check_log("no_increment_run_or_tie", inc_log, w);

      // reset during SET_HOUR auto-repeat with Set still held
      inc_log.delete();
      drive(0, 0, 1);
      n = last_cyc;
      repeat (9) drive(0, 0, 1);
      repeat (2) drive(1, 0, 1);
      repeat (8) drive(0, 0, 1);
      repeat (2) drive(0, 0, 0);
      w = {}; w.push_back(n + 1); w.push_back(n + 7); w.push_back(n + 10);
      check_log("reset_mid_repeat", inc_log, w);

      // re-press after reset in a set state increments again
      drive(0, 1, 0);
      drive(0, 0, 0);
      inc_log.delete();
      drive(0, 0, 1);
      n = last_cyc;
      repeat (3) drive(0, 0, 0);
      w = {}; w.push_back(n + 1);
      check_log("repress_after_reset", inc_log, w);

      // randomized levels with occasional reset
      rm = 1'b0;
      rs = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) rm = ~rm;
         if ($urandom_range(0, 9) == 0) rs = ~rs;
         rr = ($urandom_range(0, 199) == 0);
         drive(rr, rm, rs);
      end

      repeat (2) drive(0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/clock_mode_control.md
CLOCK_MODE_CONTROL -- requirements
Module: clock_mode_control

Interface
REQ-001 SHALL have parameter c_CLK_FREQ, default 50_000_000, meaning i_Clock cycles per second tick.
REQ-002 SHALL have parameter c_REPEAT_DELAY, default c_CLK_FREQ/2, meaning Set-button hold cycles before auto-repeat starts.
REQ-003 SHALL have parameter c_REPEAT_PERIOD, default c_CLK_FREQ/8, meaning cycles between auto-repeat pulses.
REQ-004 SHALL have port i_Clock, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_Button_Mode, input, 1, debounced synchronous level, active-high, mode select.
REQ-007 SHALL have port i_Button_Set, input, 1, debounced synchronous level, active-high, increment the selected field.
REQ-008 SHALL have port o_Reset_Sec, output, 1, clear for the seconds counters.
REQ-009 SHALL have port o_Enable_Increment, output, 1, one-cycle manual-increment strobe.
REQ-010 SHALL have port o_Enable_Count_Sec, output, 1, one-cycle 1 Hz seconds tick.
REQ-011 SHALL have port o_Enable_Count_Min, output, 1, minutes-chain enable.
REQ-012 SHALL have port o_Enable_Count_Hour, output, 1, hours-chain enable.
REQ-013 SHALL have port o_Set_Min, output, 1, high while in SET_MIN (for display blinking).
REQ-014 SHALL have port o_Set_Hour, output, 1, high while in SET_HOUR (for display blinking).

Function
REQ-015 SHALL implement FSM states RUN, SET_HOUR and SET_MIN; Mode rising edge advances RUN->SET_HOUR->SET_MIN->RUN.
REQ-016 SHALL detect rising edges as current level high AND registered previous level low, per button.
REQ-017 SHALL register all outputs; a qualifying button edge in cycle N yields a state change or strobe in cycle N+1.
REQ-018 SHALL run a prescaler 0..c_CLK_FREQ-1 in RUN only, pulsing o_Enable_Count_Sec for exactly one cycle at wrap; prescaler held at 0 outside RUN.
REQ-019 SHALL, in RUN: o_Enable_Count_Min=1, o_Enable_Count_Hour=1, o_Reset_Sec=0, o_Enable_Increment=0, Set button ignored.
REQ-020 SHALL, in SET_HOUR: o_Enable_Count_Hour=1, o_Enable_Count_Min=0, o_Enable_Count_Sec=0, o_Reset_Sec=1.
REQ-021 SHALL, in SET_MIN: o_Enable_Count_Min=1, o_Enable_Count_Hour=0 (no minute-to-hour carry), o_Enable_Count_Sec=0, o_Reset_Sec=1.
REQ-022 SHALL, in SET_HOUR/SET_MIN, pulse o_Enable_Increment for one cycle per Set rising edge.
REQ-023 SHALL, while Set stays high in a set state, issue the first repeat pulse c_REPEAT_DELAY cycles after the press pulse, then one every c_REPEAT_PERIOD cycles until release.
REQ-024 SHALL clear the repeat counter on Set release, on any state change, and in RUN.
REQ-025 SHALL, on simultaneous Mode and Set edges, take the Mode transition and drop the Set edge (no increment).
REQ-026 SHALL, on SET_MIN->RUN, start the prescaler from 0, so the first seconds tick occurs c_CLK_FREQ cycles after entering RUN.
REQ-027 SHALL keep o_Enable_Increment, o_Enable_Count_Sec and repeat pulses mutually exclusive in time; never more than one increment per cycle.

Reset
REQ-028 SHALL, while i_Reset=1, force state RUN, prescaler 0, repeat counter 0, o_Enable_Count_Sec=0, o_Enable_Increment=0, o_Reset_Sec=1, o_Enable_Count_Min=0, o_Enable_Count_Hour=0, o_Set_Min=0, o_Set_Hour=0.
REQ-029 SHALL reset both previous-level registers to 1, so a button held through reset produces no edge until released and pressed again.
REQ-030 SHALL take reset priority over all other inputs in the same cycle, including mid-setting and mid-repeat.

Verification (c_CLK_FREQ=10, c_REPEAT_DELAY=6, c_REPEAT_PERIOD=3)
REQ-031 SHALL verify: release reset, idle 35 cycles -> o_Enable_Count_Sec pulses at cycles 10, 20, 30 after release, each 1 cycle wide.
REQ-032 SHALL verify: Mode pulse at cycle N -> o_Set_Hour=1, o_Reset_Sec=1, o_Enable_Count_Min=0 from N+1; second Mode pulse -> o_Set_Min=1, o_Enable_Count_Hour=0; third -> RUN with first tick 10 cycles later.
REQ-033 SHALL verify: in SET_MIN, hold Set 15 cycles from cycle N -> o_Enable_Increment at N+1, N+7, N+10, N+13, N+16 (5 pulses), none after release.
REQ-034 SHALL verify: in RUN, Set pulses -> no o_Enable_Increment; Mode and Set rising in the same cycle from RUN -> SET_HOUR with no increment.
REQ-035 SHALL verify: assert reset during SET_HOUR auto-repeat with Set held -> next cycle RUN, outputs at reset values, no increment until Set is released and re-pressed in a set state.
